// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use and halt interlock for the 5-stage MIPS pipeline. It sits beside
//   the ID stage and gates the PC, IF/ID and ID/EX registers.
//   - A per-register 3-bit countdown (pend) tracks loads still in flight.
//   - A small FSM drains outstanding loads after a halt opcode (6'h3f), then
//     freezes fetch for good.
//   - Optional interlock cycle counter, enabled by defining HAZARD_PERF_CNT_EN.
//     When it is not defined there are no counter flops and stall_count is 0.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   d_valid         : ID holds a real instruction
//   d_instruction   : ID instruction ([31:26] opcode, [25:21] rs, [20:16] rt)
//   d_uses_rs/rt    : instruction reads rs / rt
//   d_reg_write     : instruction writes d_dest
//   d_dest          : destination register
//   d_mem_read      : instruction is a load
//   ext_stall       : memory-side freeze of the whole front end
//   pc_en, ifid_en  : PC / IF-ID may advance
//   idex_bubble     : ID/EX loads a NOP instead of the ID instruction
//   halted          : core is halted
//   stall_count     : saturating count of interlock cycles
//
// state  | meaning
// RUN    | normal issue, load-use interlock active
// DRAIN  | halt seen, waiting for every pending load to retire
// HALTED | fetch frozen until reset
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [31:0]       d_instruction,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic              d_reg_write,
  input  logic [REG_AW-1:0] d_dest,
  input  logic              d_mem_read,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [5:0] HALT_OP   = 6'h3f;
  localparam logic [2:0] LOAD_PEND = 3'(LOAD_LATENCY);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state;
  logic [2:0]        pend [NUM_REGS];

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              halt_op;
  logic              rs_busy;
  logic              rt_busy;
  logic              hazard;
  logic              issue;
  logic              drain_done;
  logic              unused_bits;

  assign opcode      = d_instruction[31:26];
  assign rs          = d_instruction[21 +: REG_AW];
  assign rt          = d_instruction[16 +: REG_AW];
  assign unused_bits = ^d_instruction[15:0];

  assign halt_op = d_valid && (opcode == HALT_OP);
  assign rs_busy = d_uses_rs && (rs != '0) && (pend[rs] != 3'd0);
  assign rt_busy = d_uses_rt && (rt != '0) && (pend[rt] != 3'd0);
  assign hazard  = d_valid && (rs_busy || rt_busy);
  assign issue   = d_valid && (state == RUN) && !hazard && !ext_stall && !halt_op;

  // Drain finishes on the edge that clears the last pending entry, so the
  // check is on the post-decrement value (every entry at most 1). This makes
  // HALTED arrive max(1, remaining pend) edges after DRAIN is entered.
  always_comb begin
    drain_done = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pend[r] > 3'd1) drain_done = 1'b0;
    end
  end

  // Issue write wins over the decrement of the same entry (later assignment).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= 3'd0;
    end else if (!ext_stall) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (pend[r] != 3'd0) pend[r] <= pend[r] - 3'd1;
      end
      if (issue && d_reg_write && (d_dest != '0)) begin
        pend[d_dest] <= d_mem_read ? LOAD_PEND : 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else if (!ext_stall) begin
      case (state)
        RUN:     if (halt_op) state <= DRAIN;
        DRAIN:   if (drain_done) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    if (ext_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if ((state != RUN) || halt_op || hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign halted = (state == HALTED);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (hazard && (state == RUN) && !halt_op && !ext_stall && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + CNT_W'(1);
    end
  end

  assign stall_count = perf_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic        valid = 1'b0, urs = 1'b0, urt = 1'b0, rw = 1'b0, mr = 1'b0, ext = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0]  dest = '0;

  logic a_valid, a_ext, b_valid, b_ext;
  assign a_valid = valid && (sel == 0);
  assign a_ext   = ext && (sel == 0);
  assign b_valid = valid && (sel == 1);
  assign b_ext   = ext && (sel == 1);

  logic        a_pc, a_ifid, a_bub, a_hlt;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_bub, b_hlt;
  logic [1:0]  b_cnt;

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LOAD_LATENCY(3), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .d_valid(a_valid), .d_instruction(instr),
    .d_uses_rs(urs), .d_uses_rt(urt), .d_reg_write(rw), .d_dest(dest),
    .d_mem_read(mr), .ext_stall(a_ext), .pc_en(a_pc), .ifid_en(a_ifid),
    .idex_bubble(a_bub), .halted(a_hlt), .stall_count(a_cnt)
  );

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LOAD_LATENCY(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .d_valid(b_valid), .d_instruction(instr),
    .d_uses_rs(urs), .d_uses_rt(urt), .d_reg_write(rw), .d_dest(dest),
    .d_mem_read(mr), .ext_stall(b_ext), .pc_en(b_pc), .ifid_en(b_ifid),
    .idex_bubble(b_bub), .halted(b_hlt), .stall_count(b_cnt)
  );

  logic        mon_pc, mon_ifid, mon_bub, mon_hlt;
  logic [15:0] mon_cnt;
  assign mon_pc   = (sel == 0) ? a_pc   : b_pc;
  assign mon_ifid = (sel == 0) ? a_ifid : b_ifid;
  assign mon_bub  = (sel == 0) ? a_bub  : b_bub;
  assign mon_hlt  = (sel == 0) ? a_hlt  : b_hlt;
  assign mon_cnt  = (sel == 0) ? a_cnt  : {14'd0, b_cnt};

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_got;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {mon_pc, mon_ifid, mon_bub, mon_hlt, mon_cnt};
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0t dut=%0d: got pc=%b ifid=%b bub=%b halted=%b cnt=%0d, expected pc=%b ifid=%b bub=%b halted=%b cnt=%0d",
                 $time, sel, mon_got.pc, mon_got.ifid, mon_got.bub, mon_got.hlt, mon_got.cnt,
                 mon_exp.pc, mon_exp.ifid, mon_exp.bub, mon_exp.hlt, mon_exp.cnt);
      end
    end
  end

  // Reference model: each register has the first cycle at which a reader may
  // issue. An external freeze pushes every future ready time back by a cycle.
  int lat = 3;
  int cw = 16;
  int cyc = 0;
  int ready_at [32];
  int mstate = 0;   // 0 running, 1 draining, 2 halted
  int mcount = 0;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    mstate = 0;
    mcount = 0;
  endfunction

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic u_rs, input logic u_rt,
                      input logic w, input logic [4:0] dst, input logic m, input logic e,
                      output logic iss, output logic o_bub, output logic o_hlt);
    logic [4:0] rsv, rtv;
    logic       halt_op, haz, all_ready;
    exp_t       ex;
    @(posedge clk);
    #1;
    valid = v; instr = ins; urs = u_rs; urt = u_rt; rw = w; dest = dst; mr = m; ext = e;
    rsv = ins[25:21];
    rtv = ins[20:16];
    halt_op = v && (ins[31:26] == 6'h3f);
    haz = v && ((u_rs && rsv != 0 && ready_at[rsv] > cyc) || (u_rt && rtv != 0 && ready_at[rtv] > cyc));
    ex.hlt = (mstate == 2);
    ex.cnt = 16'(mcount);
    if (e) {ex.pc, ex.ifid, ex.bub} = 3'b000;
    else if (mstate != 0 || halt_op || haz) {ex.pc, ex.ifid, ex.bub} = 3'b001;
    else {ex.pc, ex.ifid, ex.bub} = 3'b110;
    exp_q.push_back(ex);
    iss = v && mstate == 0 && !haz && !e && !halt_op;
    if (e) begin
      for (int r = 0; r < 32; r++) if (ready_at[r] > cyc) ready_at[r]++;
    end else begin
      if (PERF && haz && mstate == 0 && !halt_op && mcount < (1 << cw) - 1) mcount++;
      all_ready = 1'b1;
      for (int r = 0; r < 32; r++) if (ready_at[r] > cyc + 1) all_ready = 1'b0;
      if (iss && w && dst != 0) ready_at[dst] = m ? cyc + 1 + lat : 0;
      if (mstate == 0 && halt_op) mstate = 1;
      else if (mstate == 1 && all_ready) mstate = 2;
    end
    cyc++;
    #1;
    o_bub = mon_bub;
    o_hlt = mon_hlt;
  endtask

  // Hold an instruction in ID until it issues; report bubbles seen on the DUT.
  task automatic present(input logic [31:0] ins, input logic u_rs, input logic u_rt, input logic w,
                         input logic [4:0] dst, input logic m, output int bubbles);
    logic iss, ob, oh;
    bubbles = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, ins, u_rs, u_rt, w, dst, m, 1'b0, iss, ob, oh);
      if (iss) return;
      if (ob) bubbles++;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL issue_timeout: got no issue in 20 cycles expected issue");
  endtask

  task automatic idle(input int n);
    logic iss, ob, oh;
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, iss, ob, oh);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    valid = 1'b0; ext = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pc_en", int'(mon_pc), 1);
    check("rst_ifid_en", int'(mon_ifid), 1);
    check("rst_idex_bubble", int'(mon_bub), 0);
    check("rst_halted", int'(mon_hlt), 0);
    check("rst_stall_count", int'(mon_cnt), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_phase(input int n);
    logic        have, v, m, u_rs, u_rt, w, e, iss, ob, oh;
    logic [31:0] ins;
    logic [4:0]  dst;
    have = 1'b0;
    v = 0; m = 0; u_rs = 0; u_rt = 0; w = 0; ins = '0; dst = '0;
    for (int i = 0; i < n; i++) begin
      if (!have) begin
        v    = ($urandom_range(0, 99) < 90);
        m    = $urandom_range(0, 1) == 1;
        u_rs = $urandom_range(0, 1) == 1;
        u_rt = $urandom_range(0, 1) == 1;
        w    = m ? 1'b1 : ($urandom_range(0, 99) < 80);
        dst  = 5'($urandom_range(0, 7));
        ins  = {m ? 6'h23 : 6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        have = 1'b1;
      end
      e = ($urandom_range(0, 99) < 15);
      step(v, ins, u_rs, u_rt, w, dst, m, e, iss, ob, oh);
      if (iss || !v) have = 1'b0;
    end
  endtask

  localparam logic [5:0] LW = 6'h23;

  initial begin
    int   b;
    int   dc;
    logic iss, ob, oh;
    model_reset();
    do_reset();

    // Latency 3: load, unrelated op, then reader of rt.
    present({LW, 5'd0, 5'd7, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, b);
    check("lw_no_stall", b, 0);
    present({6'h00, 5'd1, 5'd2, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, b);
    check("unrelated_no_stall", b, 0);
    present({6'h00, 5'd1, 5'd7, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, b);
    check("lat3_bubbles", b, 2);
    check("lat3_stall_count", int'(mon_cnt), PERF ? 2 : 0);

    // Register 0 and ALU results never interlock.
    present({LW, 5'd0, 5'd0, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, b);
    present({6'h00, 5'd0, 5'd0, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, b);
    check("reg0_no_stall", b, 0);
    present({6'h00, 5'd1, 5'd2, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, b);
    present({6'h00, 5'd9, 5'd0, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0, b);
    check("alu_no_stall", b, 0);

    // External freeze for 4 cycles while a load is pending.
    present({LW, 5'd0, 5'd7, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, b);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, {6'h00, 5'd1, 5'd7, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, iss, ob, oh);
      check("ext_no_bubble", int'(ob), 0);
    end
    present({6'h00, 5'd1, 5'd7, 16'd0}, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, b);
    check("ext_bubbles_after", b, 3);

    rand_phase(300);
    idle(8);

    // Halt behind a latency-3 load: two drain cycles, then halted for good.
    present({LW, 5'd0, 5'd4, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, b);
    step(1'b1, {6'h3f, 26'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, iss, ob, oh);
    check("halt_op_bubble", int'(ob), 1);
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, {6'h3f, 26'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, iss, ob, oh);
      if (oh) break;
      if (ob) dc++;
    end
    check("drain_cycles", dc, 2);
    idle(6);
    check("halt_held", int'(mon_hlt), 1);
    do_reset();
    idle(3);

    // Second instance: latency 1, 2-bit saturating counter.
    sel = 1; lat = 1; cw = 2;
    do_reset();
    present({LW, 5'd0, 5'd5, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, b);
    present({6'h00, 5'd5, 5'd2, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, b);
    check("lat1_bubbles", b, 1);
    for (int k = 0; k < 4; k++) begin
      present({LW, 5'd0, 5'd5, 16'd0}, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, b);
      present({6'h00, 5'd2, 5'd5, 16'd0}, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, b);
    end
    check("sat_stall_count", int'(mon_cnt), PERF ? 3 : 0);
    rand_phase(300);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use and halt interlock for the 5-stage MIPS pipeline. It sits beside the ID stage and drives the PC, IF/ID and ID/EX enables. A per-register countdown scoreboard covers loads with configurable result latency, where a single EX-stage compare only handled one-cycle loads. A halt FSM drains outstanding loads before freezing fetch. An optional performance counter reports interlock cycles.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register 0 never creates a hazard.
- REG_AW, 5: register address width; must satisfy 2^REG_AW == NUM_REGS.
- LOAD_LATENCY, 1: stall cycles a dependent instruction needs after a load issues to EX; legal range 1..7.
- CNT_W, 16: width of stall_count.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- d_valid, input, 1: ID stage holds a real instruction.
- d_instruction, input, 32: ID instruction; bits [31:26] opcode, [25:21] rs, [20:16] rt.
- d_uses_rs, input, 1: instruction reads rs.
- d_uses_rt, input, 1: instruction reads rt.
- d_reg_write, input, 1: instruction writes d_dest.
- d_dest, input, REG_AW: destination register.
- d_mem_read, input, 1: instruction is a load.
- ext_stall, input, 1: memory-side freeze of the whole front end.
- pc_en, output, 1: PC may advance.
- ifid_en, output, 1: IF/ID may load.
- idex_bubble, output, 1: ID/EX loads a NOP instead of the ID instruction.
- halted, output, 1: core is halted.
- stall_count, output, CNT_W: interlock cycles, saturating.

## Operation
- Scoreboard: one 3-bit countdown per register, pend[r]; all zero at reset.
- Each cycle without ext_stall, every nonzero pend decrements by 1.
- issue = d_valid && state==RUN && !hazard && !ext_stall && opcode!=6'h3f.
- On issue with d_reg_write && d_dest!=0, pend[d_dest] is set to LOAD_LATENCY if d_mem_read, otherwise 0. This write overrides the decrement of that same entry.
- hazard = d_valid && ((d_uses_rs && rs!=0 && pend[rs]!=0) || (d_uses_rt && rt!=0 && pend[rt]!=0)). It is combinational from registered pend.
- FSM states:
  - RUN: normal operation. Goes to DRAIN when d_valid && opcode==6'h3f && !ext_stall.
  - DRAIN: goes to HALTED when all pend are zero and ext_stall is low.
  - HALTED: absorbing; only rst_n exits it.
- Output priority, highest first:
  - ext_stall: pc_en=0, ifid_en=0, idex_bubble=0; counters and state hold.
  - DRAIN or HALTED, or halt opcode in ID during RUN: pc_en=0, ifid_en=0, idex_bubble=1.
  - hazard: pc_en=0, ifid_en=0, idex_bubble=1.
  - otherwise: pc_en=1, ifid_en=1, idex_bubble=0.
- halted=1 only in HALTED.

## Timing
- Reset values: pend all 0, state RUN, pc_en=1, ifid_en=1, idex_bubble=0, halted=0, stall_count=0. The asynchronous reset takes effect mid-drain or mid-stall immediately.
- Stall outputs are combinational in the cycle the dependent instruction is in ID. Scoreboard and FSM update on the clk edge.
- A load issued at edge t followed by a dependent instruction gives exactly LOAD_LATENCY bubble cycles. The dependent instruction issues LOAD_LATENCY+1 cycles after the load.
- Independent instructions following a load never stall.
- The halt opcode enters DRAIN at the next edge. HALTED is reached max(1, remaining pend) edges later.
- A halt opcode arriving during ext_stall is not accepted until ext_stall drops.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_count increments by 1 on each edge where hazard=1 in RUN and ext_stall=0. It saturates at 2^CNT_W-1 and does not wrap. Halt and drain cycles are not counted.
- HAZARD_PERF_CNT_EN undefined: no counter flops; stall_count is tied to 0.

## Test plan
- LOAD_LATENCY=1: lw $5 then add using rs=$5. Expect exactly 1 cycle with idex_bubble=1 and pc_en=0, then the add issues.
- LOAD_LATENCY=3: lw $7, an unrelated instruction, then a reader of rt=$7. Expect 2 bubble cycles; stall_count reads 2 with HAZARD_PERF_CNT_EN defined, 0 without.
- lw $0 followed by a reader of $0, and an ALU write to $9 followed by a reader of $9. Expect no stall in either case.
- ext_stall held 4 cycles during a pending load. Expect pend frozen, idex_bubble=0, and the bubble count after release unchanged.
- LOAD_LATENCY=3: lw $4, then opcode 6'h3f. Expect DRAIN for 2 cycles with idex_bubble=1, then halted=1 held indefinitely. Pulsing rst_n low restores all reset values.
- CNT_W=2 with 5 hazard cycles. Expect stall_count to saturate at 3.
